// File: rtl/lsu_sequencer_if.sv
// Handshaked word-addressed data-memory bus between lsu_sequencer (master) and memory (slave).
interface lsu_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer between the memory stage and a handshaked data memory.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two transactions.
module lsu_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [2:0]        Load,
    input  logic [1:0]        Store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    lsu_sequencer_if.master   mem
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StReq2, StWait2, StResp} state_e;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [1:0]        size_q, off_q;
    logic              uns_q, we_q, cross_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [3:0]        be_hi_q;
    logic [31:0]       wdata_hi_q, first_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              done_q, err_q;
    logic [31:0]       rdata_q;

    logic [1:0]  dec_size;
    logic        dec_uns, dec_bad, dec_cross;
    logic [7:0]  be_base, dec_be;
    logic [63:0] dec_wd;

    always_comb begin
        dec_size = 2'd2;
        dec_uns  = 1'b0;
        dec_bad  = 1'b0;
        if (req_is_store) begin
            case (Store)
                2'b00:   dec_size = 2'd0;
                2'b01:   dec_size = 2'd1;
                2'b10:   dec_size = 2'd2;
                default: dec_bad  = 1'b1;
            endcase
        end else begin
            case (Load)
                3'b000:  dec_size = 2'd0;
                3'b001:  dec_size = 2'd1;
                3'b010:  dec_size = 2'd2;
                3'b011:  begin dec_size = 2'd0; dec_uns = 1'b1; end
                3'b100:  begin dec_size = 2'd1; dec_uns = 1'b1; end
                default: dec_bad = 1'b1;
            endcase
        end
        dec_cross = (dec_size == 2'd1 && addr[1:0] == 2'd3) ||
                    (dec_size == 2'd2 && addr[1:0] != 2'd0);
        case (dec_size)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            default: be_base = 8'h0f;
        endcase
        // 64-bit lane view: low half feeds the first word, high half the next word
        dec_be = be_base << addr[1:0];
        dec_wd = {32'b0, wdata} << {addr[1:0], 3'b000};
    end

    function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (size)
            2'd0:    extend = {{24{~uns & sh[7]}}, sh[7:0]};
            2'd1:    extend = {{16{~uns & sh[15]}}, sh[15:0]};
            default: extend = sh[31:0];
        endcase
    endfunction

    assign stall = (req_valid && state_q == StIdle) || (state_q != StIdle && state_q != StResp);
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            size_q      <= '0;
            off_q       <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            cross_q     <= 1'b0;
            word_addr_q <= '0;
            be_hi_q     <= '0;
            wdata_hi_q  <= '0;
            first_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        size_q      <= dec_size;
                        off_q       <= addr[1:0];
                        uns_q       <= dec_uns;
                        we_q        <= req_is_store;
                        cross_q     <= dec_cross & SplitEn;
                        word_addr_q <= {addr[ADDR_W-1:2], 2'b00};
                        be_hi_q     <= dec_be[7:4];
                        wdata_hi_q  <= dec_wd[63:32];
                        if (dec_bad || (dec_cross && !SplitEn)) begin
                            state_q <= StResp;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q     <= StReq;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_is_store;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= dec_be[3:0];
                            mem_wdata_q <= dec_wd[31:0];
                        end
                    end
                end
                StReq, StReq2: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= (state_q == StReq) ? StWait : StWait2;
                    end
                end
                StWait, StWait2: begin
                    if (mem.mem_rvalid) begin
                        first_q <= mem.mem_rdata;
                        if (state_q == StWait && cross_q) begin
                            state_q     <= StReq2;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= we_q;
                            mem_addr_q  <= word_addr_q + ADDR_W'(4);
                            mem_be_q    <= be_hi_q;
                            mem_wdata_q <= wdata_hi_q;
                        end else begin
                            state_q <= StResp;
                            done_q  <= 1'b1;
                            if (we_q) begin
                                rdata_q <= '0;
                            end else if (state_q == StWait2) begin
                                rdata_q <= extend({mem.mem_rdata, first_q}, off_q, size_q, uns_q);
                            end else begin
                                rdata_q <= extend({32'b0, mem.mem_rdata}, off_q, size_q, uns_q);
                            end
                        end
                    end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                        state_q <= StResp;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    rdata_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: byte-level reference model plus a delay-programmable memory.
module tb_lsu_sequencer;
    localparam int unsigned MAX_WAIT = 16;
    localparam int unsigned ADDR_W   = 32;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_is_store;
    logic [2:0]  Load;
    logic [1:0]  Store;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;

    lsu_sequencer_if #(.ADDR_W(ADDR_W)) mem_bus ();

    lsu_sequencer #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
        .Load(Load), .Store(Store), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata(rdata), .err(err), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] bus_mem [int unsigned];
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'((a * 37) + 11);
    endfunction
    function automatic logic [7:0] bus_rd(input int unsigned a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] ref_rd(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic preload(input int unsigned wa, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            bus_mem[wa + i] = v[8*i +: 8];
            ref_mem[wa + i] = v[8*i +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access: model prediction, drive, act as memory, then compare everything seen.
    task automatic access(input bit st, input logic [2:0] ld, input logic [1:0] sd,
                          input logic [31:0] a, input logic [31:0] wd, input int gdly,
                          input int rdly, input bit hang, input string tag);
        int n, k, exp_stall, nstall, gcnt, rcnt, w;
        bit sgn, bad, exp_err, in_req, pend, got;
        int unsigned ba;
        logic [31:0] exp_wa [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] val, exp_rd, cur_wa, msk, o_rd;
        logic        o_done, o_err;
        logic [31:0] ob_wa [$];
        logic [3:0]  ob_be [$];
        logic        ob_we [$];
        logic [31:0] ob_wd [$];

        bad = 0; sgn = 0; n = 4;
        if (st) begin
            case (sd)
                2'd0: n = 1;
                2'd1: n = 2;
                2'd2: n = 4;
                default: bad = 1;
            endcase
        end else begin
            case (ld)
                3'd0: begin n = 1; sgn = 1; end
                3'd1: begin n = 2; sgn = 1; end
                3'd2: n = 4;
                3'd3: n = 1;
                3'd4: n = 2;
                default: bad = 1;
            endcase
        end
        exp_err = bad || ((int'(a[1:0]) + n > 4) && !SPLIT);
        exp_be = '{default: '0};
        exp_wd = '{default: '0};
        exp_wa[0] = {a[31:2], 2'b00};
        exp_wa[1] = exp_wa[0] + 32'd4;
        val = '0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            ba = a + i;
            w = (ba / 4 != a / 4) ? 1 : 0;
            exp_be[w][ba % 4] = 1'b1;
            exp_wd[w][8*(ba % 4) +: 8] = wd[8*i +: 8];
            val[8*i +: 8] = ref_rd(ba);
            if (st && !exp_err) ref_mem[ba] = wd[8*i +: 8];
            if (w + 1 > k) k = w + 1;
        end
        if (n == 1)      exp_rd = sgn ? {{24{val[7]}}, val[7:0]} : {24'b0, val[7:0]};
        else if (n == 2) exp_rd = sgn ? {{16{val[15]}}, val[15:0]} : {16'b0, val[15:0]};
        else             exp_rd = val;
        if (exp_err) k = 0;
        exp_stall = exp_err ? 1 : 1 + k * (gdly + rdly + 2);
        if (hang) exp_stall = 1 + (gdly + 1) + MAX_WAIT;

        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; Load = ld; Store = sd; addr = a; wdata = wd;
        #1;
        nstall = stall ? 1 : 0;
        @(negedge clk);
        // Scramble the request inputs to prove they were latched
        req_valid = 1'b0; req_is_store = 1'($urandom); Load = 3'($urandom);
        Store = 2'($urandom); addr = $urandom; wdata = $urandom;
        in_req = 0; pend = 0; got = 0; gcnt = 0; rcnt = 0; cur_wa = '0;
        o_done = 0; o_err = 0; o_rd = '0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (stall) nstall++;
            mem_bus.mem_gnt = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (done || err) begin
                got = 1; o_done = done; o_err = err; o_rd = rdata;
            end else begin
                if (mem_bus.mem_req) begin
                    if (!in_req) begin
                        in_req = 1; gcnt = 0; cur_wa = mem_bus.mem_addr;
                        ob_wa.push_back(mem_bus.mem_addr); ob_be.push_back(mem_bus.mem_be);
                        ob_we.push_back(mem_bus.mem_we);   ob_wd.push_back(mem_bus.mem_wdata);
                    end
                    if (gcnt == gdly) begin
                        mem_bus.mem_gnt = 1'b1; in_req = 0; pend = 1; rcnt = 0;
                        if (mem_bus.mem_we)
                            for (int l = 0; l < 4; l++)
                                if (mem_bus.mem_be[l])
                                    bus_mem[mem_bus.mem_addr + l] = mem_bus.mem_wdata[8*l +: 8];
                    end else gcnt++;
                end else if (pend) begin
                    if (!hang && rcnt == rdly) begin
                        mem_bus.mem_rvalid = 1'b1; pend = 0;
                        mem_bus.mem_rdata = {bus_rd(cur_wa + 3), bus_rd(cur_wa + 2),
                                             bus_rd(cur_wa + 1), bus_rd(cur_wa)};
                    end else rcnt++;
                end
                @(negedge clk);
            end
        end
        check({tag, ".responded"}, 64'(got), 64'd1);
        check({tag, ".err"}, 64'(o_err), 64'(exp_err || hang));
        check({tag, ".done"}, 64'(o_done), 64'(!(exp_err || hang)));
        if (hang) check({tag, ".rdata"}, 64'(o_rd), 64'd0);
        else if (!st && !exp_err) check({tag, ".rdata"}, 64'(o_rd), 64'(exp_rd));
        check({tag, ".nreq"}, 64'(ob_wa.size()), 64'(hang ? 1 : k));
        for (int i = 0; i < ob_wa.size() && i < k; i++) begin
            for (int l = 0; l < 4; l++) msk[8*l +: 8] = {8{exp_be[i][l]}};
            check({tag, ".addr"}, 64'(ob_wa[i]), 64'(exp_wa[i]));
            check({tag, ".be"}, 64'(ob_be[i]), 64'(exp_be[i]));
            check({tag, ".we"}, 64'(ob_we[i]), 64'(st));
            if (st) check({tag, ".wdata"}, 64'(ob_wd[i] & msk), 64'(exp_wd[i]));
        end
        check({tag, ".stall"}, 64'(nstall), 64'(exp_stall));
    endtask

    initial begin
        req_valid = 1'b0; req_is_store = 1'b0; Load = '0; Store = '0; addr = '0; wdata = '0;
        mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst.stall", 64'(stall), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        check("rst.rdata", 64'(rdata), 64'd0);
        check("rst.req", 64'(mem_bus.mem_req), 64'd0);
        check("rst.we", 64'(mem_bus.mem_we), 64'd0);
        check("rst.be", 64'(mem_bus.mem_be), 64'd0);
        check("rst.addr", 64'(mem_bus.mem_addr), 64'd0);
        check("rst.wdata", 64'(mem_bus.mem_wdata), 64'd0);
        reset = 1'b1;

        preload(32'h100, 32'hDEADBEEF);
        access(0, 3'd2, 2'd0, 32'h100, 32'h0, 0, 1, 0, "lw100");
        preload(32'h200, 32'h80FF1234);
        access(0, 3'd0, 2'd0, 32'h203, 32'h0, 0, 0, 0, "lb203");
        access(0, 3'd3, 2'd0, 32'h203, 32'h0, 1, 0, 0, "lbu203");
        access(1, 3'd0, 2'd1, 32'h302, 32'h0000ABCD, 0, 0, 0, "sh302");
        access(0, 3'd4, 2'd0, 32'h302, 32'h0, 0, 2, 0, "lhu302");
        access(0, 3'd2, 2'd0, 32'h600, 32'h0, 0, 0, 1, "timeout");
        preload(32'h400, 32'h44332211);
        preload(32'h404, 32'h88776655);
        access(0, 3'd2, 2'd0, 32'h401, 32'h0, 0, 0, 0, "lw401");
        access(0, 3'd6, 2'd0, 32'h400, 32'h0, 0, 0, 0, "badload");
        access(1, 3'd0, 2'd3, 32'h400, 32'h0, 0, 0, 0, "badstore");

        // Reset while waiting for a response abandons the access
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; Load = 3'd2; addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        check("rw.req", 64'(mem_bus.mem_req), 64'd1);
        mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0;
        @(negedge clk);
        check("rw.stall_wait", 64'(stall), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rw.req0", 64'(mem_bus.mem_req), 64'd0);
        check("rw.stall0", 64'(stall), 64'd0);
        check("rw.done0", 64'(done), 64'd0);
        @(negedge clk);
        check("rw.nodone", 64'(done), 64'd0);
        access(0, 3'd2, 2'd0, 32'h100, 32'h0, 0, 0, 0, "lw_after_rst");

        for (int i = 0; i < 80; i++) begin
            access(1'($urandom), 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                   32'h1000 + $urandom_range(0, 47), $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0, "rand");
        end
        // Read back the randomised region so store effects are observed through loads
        for (int i = 0; i < 12; i++)
            access(0, 3'd2, 2'd0, 32'h1000 + 4 * i, 32'h0, 0, 0, 0, "readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
Multi-cycle load/store sequencer between the core's memory stage and a handshaked 32-bit word-addressed data memory. It accepts the main decoder's Load/Store encodings plus the effective address and store data. It drives byte-enabled word transactions, holds the core via stall, and returns sign- or zero-extended load data. It replaces direct single-cycle data-memory access so the core can use memories with variable latency.

Parameters:
MAX_WAIT, 16, cycles allowed in a WAIT state before a bus-timeout error (valid range 1..255)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  memory-stage instruction is a load or store
req_is_store  in  1  1 = store, 0 = load
Load  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
Store  in  2  00 sb, 01 sh, 10 sw
addr  in  ADDR_W  effective byte address
wdata  in  32  store data, right-aligned
stall  out  1  core must hold its PC and pipeline registers
done  out  1  one-cycle pulse; access completed
rdata  out  32  extended load result, valid while done=1
err  out  1  one-cycle pulse; misaligned access (feature off) or timeout
mem_req  out  1  transaction request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response or acknowledge this cycle; also used for stores
mem_rdata  in  32  read word

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE; stall, done, err, mem_req, mem_we = 0; mem_be = 0; mem_addr, mem_wdata, rdata = 0; timeout counter = 0. Reset mid-transaction abandons it; mem_req drops at that edge and no done is produced.
- States: IDLE, REQ, WAIT, REQ2, WAIT2, RESP.
- stall = req_valid & (state==IDLE) | (state != IDLE & state != RESP). Combinational, so stall asserts in the acceptance cycle. stall=0 in RESP.
- IDLE: when req_valid, latch the operation, addr, and wdata, then go to REQ.
- If the access is misaligned (half at offset 3; word at offset 1, 2, or 3) and the feature is off: go to RESP with err=1, done=0, no mem_req.
- REQ: mem_req=1, with addr/be/we/wdata stable until mem_gnt. On mem_gnt go to WAIT.
- WAIT: on mem_rvalid, capture the lanes, then go to RESP or to REQ2 (split access).
- Each WAIT/WAIT2 cycle increments the counter. If the counter reaches MAX_WAIT without rvalid: go to RESP with err=1, done=0, rdata=0.
- mem_rvalid and timeout in the same cycle: rvalid wins.
- Byte enables: sb = 0001<<off; sh = 0011<<off; sw = 1111. mem_wdata = wdata<<(8*off).
- Load extraction: byte = rdata>>(8*off), then [7:0]. lb sign-extends bit 7; lbu zero-extends. lh/lhu use bit 15 or zero. lw passes the word.
- RESP: lasts one cycle; done=1 (unless err), rdata valid. Returns to IDLE next cycle; the core advances that edge.
- Back-to-back: a req_valid present in RESP is ignored. It is accepted the following cycle in IDLE, so minimum throughput is 1 access per 4 cycles with zero-wait memory.
- Invalid encodings (Load 101..111, Store 11) are treated as misaligned: err pulse.
- mem_gnt or mem_rvalid outside the expected state is ignored.

Optional Feature:
MISALIGN_SPLIT_EN.
- Defined: a misaligned access becomes two transactions. The first goes to the word at addr[..:2]; the second (REQ2/WAIT2) goes to word+4, with the counter reset. Enables and write data come from the 64-bit shift of wdata<<(8*off): the low word for the first access, the high word for the second. Load data is assembled from {second,first}>>(8*off), then extended. An error on either half aborts with err and suppresses the second write only if it has not yet been granted.
- Undefined: misaligned → err, no bus activity, REQ2/WAIT2 unreachable.

Test Plan:
- lw addr=0x100, memory responds gnt at cycle 1 and rvalid 2 cycles later with 0xDEADBEEF → mem_addr=0x100, be=1111; done with rdata=0xDEADBEEF; stall high 4 cycles.
- lb addr=0x203, rdata=0x80FF1234; then lbu at the same address → lb gives 0xFFFFFF80, lbu gives 0x00000080; be=1000.
- sh addr=0x302, wdata=0x0000ABCD → mem_we=1, be=1100, mem_wdata=0xABCD0000, done after rvalid.
- Timeout: mem_gnt then no rvalid for MAX_WAIT=16 cycles → err pulse at cycle 16 of WAIT, done=0, stall released.
- Misaligned lw addr=0x401:
  - feature off → err, no mem_req.
  - feature on, memory words 0x44332211 and 0x88776655 → two requests (0x400, 0x404), rdata=0x55443322.
- reset=0 asserted during WAIT → next cycle state IDLE, mem_req=0, stall=0, no done. A later lw completes normally.
